// File: rtl/booth_divider.sv
// Sequential signed restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, loaded serially.
// Optional macro DIV_OVF_SAT_EN saturates the quotient on overflow instead of wrapping.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [2:0]       state_dbg_o
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW + 1);

    // Largest quotient magnitudes that still fit a signed WIDTH-bit result.
    localparam logic [DW-1:0] Q_POS_MAG = {{(DW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [DW-1:0] Q_NEG_MAG = {{(DW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

`ifdef DIV_OVF_SAT_EN
    localparam logic [WIDTH-1:0] Q_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_LO  = 3'd1,
        S_LOAD_DIV = 3'd2,
        S_CALC     = 3'd3,
        S_FIX      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    shreg_q;      // raw dividend while loading, then dividend/quotient shift register
    logic [WIDTH:0]   rem_q;        // partial remainder magnitude
    logic [WIDTH-1:0] dvs_q;        // divisor magnitude
    logic [CW-1:0]    cnt_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             dbz_pend_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmd_q;
    logic             ovf_q;
    logic             dbz_q;

    logic [WIDTH+1:0] rem_sh;
    logic             step_ge;
    logic [WIDTH:0]   rem_d;
    logic [DW-1:0]    shreg_d;
    logic [CW-1:0]    cnt_d;
    logic [DW-1:0]    dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic             ovf_d;
    logic [WIDTH-1:0] quot_wrap_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] rmd_d;

    always_comb begin
        rem_sh      = {rem_q, shreg_q[DW-1]};
        step_ge     = rem_sh >= {2'b00, dvs_q};
        rem_d       = step_ge ? (WIDTH+1)'(rem_sh - {2'b00, dvs_q}) : (WIDTH+1)'(rem_sh);
        shreg_d     = {shreg_q[DW-2:0], step_ge};
        cnt_d       = cnt_q - CW'(1);

        dvd_mag_d   = shreg_q[DW-1] ? -shreg_q : shreg_q;
        dvs_mag_d   = data_in[WIDTH-1] ? -data_in : data_in;

        ovf_d       = sign_q_q ? (shreg_q > Q_NEG_MAG) : (shreg_q > Q_POS_MAG);
        quot_wrap_d = WIDTH'(sign_q_q ? -shreg_q : shreg_q);
`ifdef DIV_OVF_SAT_EN
        quot_d      = ovf_d ? (sign_q_q ? Q_SAT_NEG : Q_SAT_POS) : quot_wrap_d;
`else
        quot_d      = quot_wrap_d;
`endif
        rmd_d       = WIDTH'(sign_r_q ? -rem_q : rem_q);
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rmd_q      <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shreg_q[DW-1:WIDTH] <= data_in;
                        busy_q              <= 1'b1;
                        state_q             <= S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    if (data_valid) begin
                        shreg_q[WIDTH-1:0] <= data_in;
                        state_q            <= S_LOAD_DIV;
                    end
                end
                S_LOAD_DIV: begin
                    if (data_valid) begin
                        if (data_in == '0) begin
                            // Zero divisor skips the datapath; DONE publishes the status one cycle later.
                            dvs_q      <= '0;
                            dbz_pend_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            dvs_q    <= dvs_mag_d;
                            shreg_q  <= dvd_mag_d;
                            rem_q    <= '0;
                            sign_q_q <= shreg_q[DW-1] ^ data_in[WIDTH-1];
                            sign_r_q <= shreg_q[DW-1];
                            cnt_q    <= CW'(DW);
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q   <= rem_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_d;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quot_q  <= quot_d;
                    rmd_q   <= rmd_d;
                    ovf_q   <= ovf_d;
                    dbz_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (dbz_pend_q) begin
                        dbz_pend_q <= 1'b0;
                        quot_q     <= '0;
                        rmd_q      <= '0;
                        ovf_q      <= 1'b0;
                        dbz_q      <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (start) begin
                        shreg_q[DW-1:WIDTH] <= data_in;
                        done_q              <= 1'b0;
                        ovf_q               <= 1'b0;
                        dbz_q               <= 1'b0;
                        busy_q              <= 1'b1;
                        state_q             <= S_LOAD_LO;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider (WIDTH=8); honours DIV_OVF_SAT_EN for overflow quotients.
module tb_booth_divider;

    logic       clk_100MHz = 1'b0;
    logic       rst        = 1'b1;
    logic       start      = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       overflow;
    logic       div_by_zero;
    logic [2:0] state_dbg_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DIV_OVF_SAT_EN
    localparam logic [7:0] EXP_Q_1000_2  = 8'h7F;
    localparam logic [7:0] EXP_Q_MIN_NEG = 8'h7F;
`else
    localparam logic [7:0] EXP_Q_1000_2  = 8'hF4;
    localparam logic [7:0] EXP_Q_MIN_NEG = 8'h00;
`endif

    booth_divider #(.WIDTH(8)) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .overflow   (overflow),
        .div_by_zero(div_by_zero),
        .state_dbg_o(state_dbg_o)
    );

    // Clock and reset
    always #5 clk_100MHz = ~clk_100MHz;

    // Driver tasks: every task starts and ends 1 ns after a rising edge.
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_load(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                           input bit dv_with_start);
        start      = 1'b1;
        data_valid = dv_with_start;
        data_in    = hi;
        tick();
        start      = 1'b0;
        data_valid = 1'b1;
        data_in    = lo;
        tick();
        data_in    = dv;
        tick();
        data_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    // Counts edges until done; busy must stay high before done and drop with it.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            lat++;
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({busy, done, overflow, div_by_zero} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, overflow, div_by_zero});
        end
        n_cmp++;
        if ({quotient, remainder} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 0000", {quotient, remainder});
        end
        @(posedge clk_100MHz);
        #1;
        rst = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'h42;
        tick();
        tick();
        data_valid = 1'b0;
        n_cmp++;
        if ({busy, state_dbg_o} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_dv_ignored: got busy/state %b expected 0000", {busy, state_dbg_o});
        end
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        do_load(8'h00, 8'h0F, 8'h03, 1'b1);
        wait_done(lat, bok);
        n_cmp++;
        if (lat !== 17) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d expected 17", lat);
        end
        n_cmp++;
        if (bok !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy: got busy_ok %0d expected 1", bok);
        end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {8'h05, 8'h00, 2'b00}) begin
            n_bad++;
            $display("FAIL basic_15_3: got q=%h r=%h ovf=%b dbz=%b expected q=05 r=00 ovf=0 dbz=0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_signs();
        logic [7:0] hi [3] = '{8'hFF, 8'h00, 8'hFF};
        logic [7:0] lo [3] = '{8'hF1, 8'h11, 8'hEF};
        logic [7:0] dv [3] = '{8'h03, 8'hFB, 8'h05};
        logic [7:0] eq [3] = '{8'hFB, 8'hFD, 8'hFD};
        logic [7:0] er [3] = '{8'h00, 8'h02, 8'hFE};
        int lat;
        bit bok;
        for (int i = 0; i < 3; i++) begin
            do_load(hi[i], lo[i], dv[i], 1'b0);
            wait_done(lat, bok);
            n_cmp++;
            if ({quotient, remainder, overflow, lat} !== {eq[i], er[i], 1'b0, 17}) begin
                n_bad++;
                $display("FAIL signs_%0d: got q=%h r=%h ovf=%b lat=%0d expected q=%h r=%h ovf=0 lat=17",
                         i, quotient, remainder, overflow, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_range();
        logic [7:0] hi  [3] = '{8'h3F, 8'h03, 8'h80};
        logic [7:0] lo  [3] = '{8'h01, 8'hE8, 8'h00};
        logic [7:0] dv  [3] = '{8'h7F, 8'h02, 8'hFF};
        logic [7:0] eq  [3] = '{8'h7F, EXP_Q_1000_2, EXP_Q_MIN_NEG};
        logic       eo  [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        bit bok;
        for (int i = 0; i < 3; i++) begin
            do_load(hi[i], lo[i], dv[i], 1'b0);
            wait_done(lat, bok);
            n_cmp++;
            if ({quotient, remainder, overflow, div_by_zero} !== {eq[i], 8'h00, eo[i], 1'b0}) begin
                n_bad++;
                $display("FAIL range_%0d: got q=%h r=%h ovf=%b dbz=%b expected q=%h r=00 ovf=%b dbz=0",
                         i, quotient, remainder, overflow, div_by_zero, eq[i], eo[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit bok;
        do_load(8'h12, 8'h34, 8'h00, 1'b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({lat, bok} !== {32'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL dbz_latency: got lat=%0d busy_ok=%0d expected lat=1 busy_ok=1", lat, bok);
        end
        n_cmp++;
        if ({quotient, remainder, overflow, div_by_zero} !== {8'h00, 8'h00, 2'b01}) begin
            n_bad++;
            $display("FAIL dbz_result: got q=%h r=%h ovf=%b dbz=%b expected q=00 r=00 ovf=0 dbz=1",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_ignore();
        int lat;
        bit bok;
        // 100 / 7 with a stray start and data_valid injected mid-CALC
        do_load(8'h00, 8'h64, 8'h07, 1'b0);
        tick();
        tick();
        tick();
        start      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hAA;
        tick();
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        wait_done(lat, bok);
        n_cmp++;
        if ({quotient, remainder, lat} !== {8'h0E, 8'h02, 32'd13}) begin
            n_bad++;
            $display("FAIL calc_start_ignored: got q=%h r=%h lat=%0d expected q=0e r=02 lat=13",
                     quotient, remainder, lat);
        end
        data_valid = 1'b1;
        data_in    = 8'h55;
        tick();
        tick();
        data_valid = 1'b0;
        n_cmp++;
        if ({quotient, remainder, done, state_dbg_o} !== {8'h0E, 8'h02, 1'b1, 3'd5}) begin
            n_bad++;
            $display("FAIL done_dv_ignored: got q=%h r=%h done=%b state=%0d expected q=0e r=02 done=1 state=5",
                     quotient, remainder, done, state_dbg_o);
        end
        start   = 1'b1;
        data_in = 8'hFF;
        tick();
        start   = 1'b0;
        n_cmp++;
        if ({done, busy, quotient, state_dbg_o} !== {1'b0, 1'b1, 8'h0E, 3'd1}) begin
            n_bad++;
            $display("FAIL done_restart: got done=%b busy=%b q=%h state=%0d expected done=0 busy=1 q=0e state=1",
                     done, busy, quotient, state_dbg_o);
        end
        data_valid = 1'b1;
        data_in    = 8'h9C;
        tick();
        data_in    = 8'h07;
        tick();
        data_valid = 1'b0;
        wait_done(lat, bok);
        n_cmp++;
        if ({quotient, remainder, lat, bok} !== {8'hF2, 8'hFE, 32'd17, 1'b1}) begin
            n_bad++;
            $display("FAIL back_to_back: got q=%h r=%h lat=%0d busy_ok=%0d expected q=f2 r=fe lat=17 busy_ok=1",
                     quotient, remainder, lat, bok);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        bit bok;
        do_load(8'h00, 8'h0F, 8'h03, 1'b0);
        tick();
        tick();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, overflow, div_by_zero, quotient, remainder, state_dbg_o} !== 23'd0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b done=%b ovf=%b dbz=%b q=%h r=%h state=%0d expected all 0",
                     busy, done, overflow, div_by_zero, quotient, remainder, state_dbg_o);
        end
        @(posedge clk_100MHz);
        #1;
        rst = 1'b0;
        tick();
        do_load(8'h00, 8'h0F, 8'h03, 1'b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quotient, remainder, overflow, lat, bok} !== {8'h05, 8'h00, 1'b0, 32'd17, 1'b1}) begin
            n_bad++;
            $display("FAIL post_reset_15_3: got q=%h r=%h ovf=%b lat=%0d busy_ok=%0d expected q=05 r=00 ovf=0 lat=17 busy_ok=1",
                     quotient, remainder, overflow, lat, bok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_range();
        test_div_zero();
        test_ignore();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
